// File: rtl/median_result_writer.sv
// Write-back stage for the median filter: buffers {address, pixel} pairs in a
// small FIFO and drains them to frame memory over a req/ack handshake.
module median_result_writer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 19,
  parameter int FIFO_DEPTH = 16,
  parameter int LAST_ADDR  = 307199
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               in_pixel,
  input  logic [ADDR_W-1:0]               in_address,
  input  logic                            in_valid,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_data,
  output logic                            mem_we,
  input  logic                            mem_ack,
  output logic                            frame_done,
  output logic [ADDR_W-1:0]               wr_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t state, next_state;

  logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic                     full, not_empty, pop, push, ack_accept;

  assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign not_empty  = (fifo_level != '0);
  assign ack_accept = (state == WRITE) && mem_ack;
  // The output register is refilled whenever it is free or being freed.
  assign pop        = not_empty && ((state == IDLE) || ack_accept);
  assign push       = in_valid && (!full || pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (not_empty) next_state = WRITE;
      WRITE:   if (mem_ack && !not_empty) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_we = (state == WRITE);
    busy   = not_empty | mem_we;
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and level alone, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_address, in_pixel};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      if (in_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      mem_data <= '0;
    end else if (pop) begin
      {mem_addr, mem_data} <= fifo_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= ack_accept && (mem_addr == ADDR_W'(LAST_ADDR));
      if (ack_accept) begin
        if (mem_addr == ADDR_W'(LAST_ADDR)) wr_count <= '0;
        else                                wr_count <= wr_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_median_result_writer.sv
// Randomized and directed bench for median_result_writer; a queue-based
// reference model feeds a scoreboard that a negedge monitor drains.
module tb_median_result_writer;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 19;
  localparam int FIFO_DEPTH = 16;
  localparam int LAST_ADDR  = 307199;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_pixel;
  logic [ADDR_W-1:0] in_address;
  logic              in_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              mem_ack;
  logic              frame_done;
  logic [ADDR_W-1:0] wr_count;
  logic [4:0]        fifo_level;
  logic              overflow;
  logic              busy;

  median_result_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .LAST_ADDR(LAST_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_address(in_address),
    .in_valid(in_valid), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_ack(mem_ack), .frame_done(frame_done),
    .wr_count(wr_count), .fifo_level(fifo_level), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } pair_t;

  int checks = 0;
  int errors = 0;
  int n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of buffered pairs plus one "in flight"
  // write slot; exp_q holds every accepted pair awaiting its memory write.
  pair_t fq[$];
  pair_t exp_q[$];
  pair_t m_head;
  bit    m_held, m_ovf, m_fdone;
  int    m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete(); exp_q.delete();
      m_held = 0; m_ovf = 0; m_fdone = 0; m_cnt = 0;
      m_head = '{a: '0, d: '0};
    end else begin
      bit ack_eff, do_pop, accept;
      pair_t p;
      ack_eff = m_held && mem_ack;
      do_pop  = (fq.size() > 0) && (!m_held || ack_eff);
      accept  = in_valid && ((fq.size() < FIFO_DEPTH) || do_pop);
      if (in_valid && !accept) m_ovf = 1;
      m_fdone = ack_eff && (m_head.a == LAST_ADDR);
      if (ack_eff) m_cnt = (m_head.a == LAST_ADDR) ? 0 : m_cnt + 1;
      if (do_pop) begin
        m_head = fq.pop_front();
        m_held = 1;
      end else if (ack_eff) begin
        m_held = 0;
      end
      if (accept) begin
        p = '{a: in_address, d: in_pixel};
        fq.push_back(p);
        exp_q.push_back(p);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we && mem_ack) begin
        n_writes++;
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          pair_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(mem_addr), 32'(e.a));
          check("write_data", 32'(mem_data), 32'(e.d));
        end
      end
      check("mem_we", 32'(mem_we), 32'(m_held));
      check("fifo_level", 32'(fifo_level), 32'(fq.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("wr_count", 32'(wr_count), 32'(m_cnt));
      check("frame_done", 32'(frame_done), 32'(m_fdone));
      check("busy", 32'(busy), 32'((fq.size() != 0) || m_held));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit v, input int a, input int d);
    in_valid   = v;
    in_address = ADDR_W'(a);
    in_pixel   = DATA_W'(d);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_addr"},   32'(mem_addr),   0);
    check({tag, "_mem_data"},   32'(mem_data),   0);
    check({tag, "_mem_we"},     32'(mem_we),     0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_wr_count"},   32'(wr_count),   0);
    check({tag, "_fifo_level"}, 32'(fifo_level), 0);
    check({tag, "_overflow"},   32'(overflow),   0);
    check({tag, "_busy"},       32'(busy),       0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; drive(0, 0, 0); mem_ack = 0;
    #1 check_all_zero("reset");
    tick(); tick();
    rst = 0;
  endtask

  task automatic push_seq(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(1, base + i, (base + i) * 7 + 3);
      tick();
    end
    drive(0, 0, 0);
  endtask

  task automatic drain(input int budget);
    int k;
    mem_ack = 1;
    k = 0;
    while (busy && k < budget) begin tick(); k++; end
    @(negedge clk);
    check("drain_idle", 32'(busy), 0);
    tick();
  endtask

  initial begin
    int saved;
    rst = 1; drive(0, 0, 0); mem_ack = 0;
    tick(); tick();
    @(negedge clk) check_all_zero("por");
    tick(); rst = 0;

    // Single write, ack held high: mem_we only in cycle 2.
    mem_ack = 1;
    drive(1, 100, 8'h5A); tick(); drive(0, 0, 0);
    @(negedge clk) check("single_c1_we", 32'(mem_we), 0);
    tick();
    @(negedge clk) begin
      check("single_c2_we", 32'(mem_we), 1);
      check("single_c2_addr", 32'(mem_addr), 100);
      check("single_c2_data", 32'(mem_data), 32'h5A);
    end
    tick();
    @(negedge clk) begin
      check("single_c3_we", 32'(mem_we), 0);
      check("single_c3_busy", 32'(busy), 0);
      check("single_c3_count", 32'(wr_count), 1);
    end

    // Burst of 8 behind a 10-cycle stall.
    do_reset();
    push_seq(8, 0);
    @(negedge clk) begin
      check("burst_peak_level", 32'(fifo_level), 7);
      check("burst_stall_addr", 32'(mem_addr), 0);
    end
    tick(); tick();
    drain(30);
    check("burst_count", 32'(wr_count), 8);

    // Overflow: 18 pairs with memory stalled, pair 17 dropped.
    do_reset();
    push_seq(18, 0);
    @(negedge clk) begin
      check("ovf_level", 32'(fifo_level), 16);
      check("ovf_flag", 32'(overflow), 1);
    end
    drain(40);
    check("ovf_count", 32'(wr_count), 17);
    check("ovf_sticky", 32'(overflow), 1);

    // Full FIFO with a simultaneous pop accepts the incoming pair.
    do_reset();
    push_seq(17, 0);
    drive(1, 50, 8'hC3); mem_ack = 1; tick();
    drive(0, 0, 0); mem_ack = 0;
    @(negedge clk) begin
      check("fullpop_level", 32'(fifo_level), 16);
      check("fullpop_ovf", 32'(overflow), 0);
    end
    drain(40);
    check("fullpop_count", 32'(wr_count), 18);

    // Frame end.
    do_reset();
    mem_ack = 1;
    drive(1, LAST_ADDR - 1, 1); tick();
    drive(1, LAST_ADDR, 2);     tick();
    drive(1, 0, 3);             tick();
    drive(0, 0, 0);
    @(negedge clk) begin
      check("frame_pre_done", 32'(frame_done), 0);
      check("frame_pre_count", 32'(wr_count), 1);
    end
    tick();
    @(negedge clk) begin
      check("frame_done_pulse", 32'(frame_done), 1);
      check("frame_count_zero", 32'(wr_count), 0);
    end
    tick();
    @(negedge clk) begin
      check("frame_done_fall", 32'(frame_done), 0);
      check("frame_next_count", 32'(wr_count), 1);
    end

    // Reset in the middle of a stalled write with 5 entries buffered.
    do_reset();
    push_seq(6, 200);
    @(negedge clk) begin
      check("midrst_level", 32'(fifo_level), 5);
      check("midrst_we", 32'(mem_we), 1);
    end
    @(posedge clk); #2;
    rst = 1;
    #1 check_all_zero("midrst");
    tick(); tick();
    rst = 0; mem_ack = 1;
    saved = n_writes;
    repeat (10) tick();
    check("midrst_no_writes", 32'(n_writes - saved), 0);

    // Randomized traffic with varying memory availability.
    do_reset();
    for (int ph = 0; ph < 6; ph++) begin
      int ack_pct, vld_pct;
      ack_pct = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 60 : 100;
      vld_pct = (ph < 3) ? 50 : 90;
      for (int c = 0; c < 400; c++) begin
        int a;
        a = ($urandom_range(0, 7) == 0) ? LAST_ADDR : int'($urandom_range(0, LAST_ADDR + 4));
        drive($urandom_range(1, 100) <= vld_pct, a, int'($urandom_range(0, 255)));
        mem_ack = ($urandom_range(1, 100) <= ack_pct);
        tick();
      end
    end
    drive(0, 0, 0);
    drain(100);
    check("rand_scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
